// File: rtl/prism_sp_ring_cookie_arbiter.sv
// Round-robin ring-acquire arbiter that stamps each accepted word into a cookie (channel, seq, desc addr, payload).
// Latency 1 cycle; in_ready drops for all channels while a cookie is held and out_ready is low.
module prism_sp_ring_cookie_arbiter #(
  parameter int NUM_CHANNELS      = 2,
  parameter int DATA_IN_WIDTH     = 32,
  parameter int DATA_OUT_WIDTH    = 64,
  parameter int SYSTEM_ADDR_WIDTH = 32,
  parameter int SEQ_WIDTH         = 8,
  parameter int TAG_MODE          = 1,
  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic [NUM_CHANNELS-1:0]                   in_valid,
  output logic [NUM_CHANNELS-1:0]                   in_ready,
  input  logic [NUM_CHANNELS*DATA_IN_WIDTH-1:0]     in_data,
  input  logic [NUM_CHANNELS*SYSTEM_ADDR_WIDTH-1:0] in_dma_desc_cur,
  input  logic [NUM_CHANNELS-1:0]                   seq_clear,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [DATA_OUT_WIDTH-1:0]                 out_data,
  output logic [CH_W-1:0]                           out_channel
);

  localparam int PAY_W = DATA_OUT_WIDTH - CH_W - SEQ_WIDTH - SYSTEM_ADDR_WIDTH;

  logic [CH_W-1:0]              rr_ptr;
  logic [CH_W-1:0]              rr_nxt;
  logic [SEQ_WIDTH-1:0]         seq [NUM_CHANNELS];
  logic                         gnt_any;
  logic [CH_W-1:0]              gnt_idx;
  logic [DATA_IN_WIDTH-1:0]     sel_data;
  logic [SYSTEM_ADDR_WIDTH-1:0] sel_addr;
  logic [SEQ_WIDTH-1:0]         sel_seq;
  logic                         xfer;
  logic [DATA_OUT_WIDTH-1:0]    cookie;
  logic                         unused_bits;

  // Second pass overrides the wrap candidate with the lowest requester at or above rr_ptr.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
      if (in_valid[k]) begin
        gnt_any = 1'b1;
        gnt_idx = CH_W'(k);
      end
    end
    for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
      if (in_valid[k] && (k >= int'(rr_ptr))) begin
        gnt_idx = CH_W'(k);
      end
    end
  end

  always_comb begin
    sel_data = '0;
    sel_addr = '0;
    sel_seq  = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (int'(gnt_idx) == k) begin
        sel_data = in_data[k*DATA_IN_WIDTH +: DATA_IN_WIDTH];
        sel_addr = in_dma_desc_cur[k*SYSTEM_ADDR_WIDTH +: SYSTEM_ADDR_WIDTH];
        sel_seq  = seq[k];
      end
    end
  end

  assign xfer   = gnt_any && (!out_valid || out_ready) && !reset;
  assign rr_nxt = (int'(gnt_idx) == NUM_CHANNELS - 1) ? '0 : gnt_idx + CH_W'(1);

  always_comb begin
    in_ready = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (xfer && (int'(gnt_idx) == k)) begin
        in_ready[k] = 1'b1;
      end
    end
  end

  // Parts of the selected word are dropped depending on TAG_MODE and payload width.
  assign unused_bits = ^{sel_data, sel_addr, sel_seq};

  if (NUM_CHANNELS < 1 || NUM_CHANNELS > 16) begin : g_bad_nc
    $fatal(1, "NUM_CHANNELS must be within 1..16");
    assign cookie = '0;
  end else if (TAG_MODE != 0 && PAY_W < 0) begin : g_bad_width
    $fatal(1, "DATA_OUT_WIDTH too narrow for tagged cookie");
    assign cookie = '0;
  end else if (TAG_MODE == 0) begin : g_pass
    assign cookie = DATA_OUT_WIDTH'(sel_data);
  end else if (PAY_W == 0) begin : g_tag_nopay
    assign cookie = {gnt_idx, sel_seq, sel_addr};
  end else begin : g_tag
    assign cookie = {gnt_idx, sel_seq, sel_addr, PAY_W'(sel_data)};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_channel <= '0;
      rr_ptr      <= '0;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        seq[k] <= '0;
      end
    end else begin
      // Clear beats increment; the cookie already captured the pre-clear value.
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        if (seq_clear[k]) begin
          seq[k] <= '0;
        end else if (xfer && (int'(gnt_idx) == k)) begin
          seq[k] <= seq[k] + SEQ_WIDTH'(1);
        end
      end
      if (xfer) begin
        out_valid   <= 1'b1;
        out_data    <= cookie;
        out_channel <= gnt_idx;
        rr_ptr      <= rr_nxt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prism_sp_ring_cookie_arbiter.sv
// Directed bench: cycle table for arbitration/stall/cookie layout plus hand-written seq, clear and reset sequences.
module tb_prism_sp_ring_cookie_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  in_valid;
  logic [1:0]  seq_clear;
  logic [63:0] in_data;
  logic [63:0] in_dma_desc_cur;
  logic        out_ready;

  logic [1:0]  in_ready,  in_ready2,  in_ready_pt;
  logic        out_valid, out_valid2, out_valid_pt;
  logic [63:0] out_data,  out_data2,  out_data_pt;
  logic        out_channel, out_channel2, out_channel_pt;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  prism_sp_ring_cookie_arbiter u_dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dma_desc_cur(in_dma_desc_cur), .seq_clear(seq_clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_channel(out_channel)
  );

  prism_sp_ring_cookie_arbiter #(.SEQ_WIDTH(2)) u_dut_seq2 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_dma_desc_cur(in_dma_desc_cur), .seq_clear(seq_clear),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_channel(out_channel2)
  );

  prism_sp_ring_cookie_arbiter #(.TAG_MODE(0)) u_dut_pt (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_pt),
    .in_data(in_data), .in_dma_desc_cur(in_dma_desc_cur), .seq_clear(seq_clear),
    .out_valid(out_valid_pt), .out_ready(out_ready), .out_data(out_data_pt), .out_channel(out_channel_pt)
  );

  typedef struct {
    logic [1:0]  v;
    logic        rdy;
    logic [31:0] d0, a0, d1, a1;
    logic [1:0]  e_rdy;
    logic        e_vld;
    logic        e_ch;
    logic [7:0]  e_seq;
    logic [31:0] e_addr;
    logic [31:0] e_pay;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] v, input logic rdy,
                     input logic [31:0] d0, input logic [31:0] a0,
                     input logic [31:0] d1, input logic [31:0] a1,
                     input logic [1:0] e_rdy, input logic e_vld, input logic e_ch,
                     input logic [7:0] e_seq, input logic [31:0] e_addr, input logic [31:0] e_pay);
    vec_t t;
    t.v = v; t.rdy = rdy; t.d0 = d0; t.a0 = a0; t.d1 = d1; t.a1 = a1;
    t.e_rdy = e_rdy; t.e_vld = e_vld; t.e_ch = e_ch; t.e_seq = e_seq;
    t.e_addr = e_addr; t.e_pay = e_pay;
    tbl.push_back(t);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    reset = 1'b1; in_valid = 2'b11; out_ready = 1'b0; seq_clear = 2'b00;
    @(negedge clock);
    #1 check({tag, "_rdy_in_reset"}, 64'(in_ready), 64'h0);
    @(negedge clock);
    reset = 1'b0; in_valid = 2'b00;
    #1;
    check({tag, "_vld_after_reset"}, 64'(out_valid), 64'h0);
    check({tag, "_data_after_reset"}, out_data, 64'h0);
    check({tag, "_ch_after_reset"}, 64'(out_channel), 64'h0);
  endtask

  initial begin
    reset = 1'b1; in_valid = '0; seq_clear = '0; in_data = '0; in_dma_desc_cur = '0; out_ready = 1'b0;

    //   v     rdy d0          a0          d1            a1          e_rdy e_vld ch seq addr        pay
    add(2'b01, 1, 32'h1234, 32'h1000, 32'h0,        32'h0,      2'b01, 0, 0, 0, 32'h0,    32'h0);
    add(2'b00, 1, 32'h1234, 32'h1000, 32'h0,        32'h0,      2'b00, 1, 0, 0, 32'h1000, 32'h1234);
    add(2'b11, 1, 32'h1111, 32'h1100, 32'h2222,     32'h2200,   2'b10, 0, 0, 0, 32'h0,    32'h0);
    add(2'b11, 1, 32'h1111, 32'h1100, 32'h2222,     32'h2200,   2'b01, 1, 1, 0, 32'h2200, 32'h2222);
    add(2'b11, 1, 32'h1111, 32'h1100, 32'h2222,     32'h2200,   2'b10, 1, 0, 1, 32'h1100, 32'h1111);
    add(2'b11, 1, 32'h1111, 32'h1100, 32'h2222,     32'h2200,   2'b01, 1, 1, 1, 32'h2200, 32'h2222);
    for (int s = 0; s < 5; s++)
      add(2'b11, 0, 32'hAAAA, 32'hA000, 32'hBBBB,   32'hB000,   2'b00, 1, 0, 2, 32'h1100, 32'h1111);
    add(2'b11, 1, 32'hAAAA, 32'hA000, 32'hBBBB,     32'hB000,   2'b10, 1, 0, 2, 32'h1100, 32'h1111);
    add(2'b00, 0, 32'h0,    32'h0,    32'h0,        32'h0,      2'b00, 1, 1, 2, 32'hB000, 32'hBBBB);
    add(2'b00, 1, 32'h0,    32'h0,    32'h0,        32'h0,      2'b00, 1, 1, 2, 32'hB000, 32'hBBBB);
    add(2'b00, 0, 32'h0,    32'h0,    32'h0,        32'h0,      2'b00, 0, 0, 0, 32'h0,    32'h0);
    add(2'b10, 0, 32'h0,    32'h0,    32'hFFABCDEF, 32'h3300,   2'b10, 0, 0, 0, 32'h0,    32'h0);
    add(2'b00, 0, 32'h0,    32'h0,    32'h0,        32'h0,      2'b00, 1, 1, 3, 32'h3300, 32'hFFABCDEF);
    add(2'b01, 1, 32'h4444, 32'h4400, 32'h0,        32'h0,      2'b01, 1, 1, 3, 32'h3300, 32'hFFABCDEF);
    add(2'b01, 1, 32'h5555, 32'h5500, 32'h0,        32'h0,      2'b01, 1, 0, 3, 32'h4400, 32'h4444);
    add(2'b00, 1, 32'h0,    32'h0,    32'h0,        32'h0,      2'b00, 1, 0, 4, 32'h5500, 32'h5555);
    add(2'b00, 1, 32'h0,    32'h0,    32'h0,        32'h0,      2'b00, 0, 0, 0, 32'h0,    32'h0);

    do_reset("init");

    foreach (tbl[i]) begin
      @(negedge clock);
      in_valid        = tbl[i].v;
      out_ready       = tbl[i].rdy;
      in_data         = {tbl[i].d1, tbl[i].d0};
      in_dma_desc_cur = {tbl[i].a1, tbl[i].a0};
      #1;
      check($sformatf("r%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].e_rdy));
      check($sformatf("r%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].e_vld));
      if (tbl[i].e_vld) begin
        check($sformatf("r%0d_out_channel", i), 64'(out_channel), 64'(tbl[i].e_ch));
        check($sformatf("r%0d_cookie_ch", i), 64'(out_data[63]), 64'(tbl[i].e_ch));
        check($sformatf("r%0d_cookie_seq", i), 64'(out_data[62:55]), 64'(tbl[i].e_seq));
        check($sformatf("r%0d_cookie_addr", i), 64'(out_data[54:23]), 64'(tbl[i].e_addr));
        check($sformatf("r%0d_cookie_pay", i), 64'(out_data[22:0]), 64'(tbl[i].e_pay[22:0]));
        check($sformatf("r%0d_seq2_seq", i), 64'(out_data2[62:61]), 64'(tbl[i].e_seq[1:0]));
        check($sformatf("r%0d_pt_data", i), out_data_pt, {32'h0, tbl[i].e_pay});
      end
    end

    // Five back-to-back transfers on channel 1: 2-bit counter wraps, 8-bit keeps counting.
    do_reset("wrap");
    in_data = {32'h00C0FFEE, 32'h0}; in_dma_desc_cur = {32'h7700, 32'h0};
    for (int k = 0; k <= 5; k++) begin
      @(negedge clock);
      in_valid = (k < 5) ? 2'b10 : 2'b00;
      out_ready = 1'b1;
      #1;
      if (k > 0) begin
        check($sformatf("wrap%0d_vld", k), 64'(out_valid), 64'h1);
        check($sformatf("wrap%0d_ch", k), 64'(out_channel), 64'h1);
        check($sformatf("wrap%0d_seq8", k), 64'(out_data[62:55]), 64'(k - 1));
        check($sformatf("wrap%0d_seq2", k), 64'(out_data2[62:61]), 64'((k - 1) % 4));
      end
    end

    // Clear coincident with a channel-0 transfer at seq 3.
    do_reset("clr");
    in_data = {32'h0, 32'h00000ABC}; in_dma_desc_cur = {32'h0, 32'h8800};
    for (int k = 0; k <= 5; k++) begin
      @(negedge clock);
      in_valid  = (k < 5) ? 2'b01 : 2'b00;
      seq_clear = (k == 3) ? 2'b01 : 2'b00;
      out_ready = 1'b1;
      #1;
      if (k > 0) begin
        check($sformatf("clr%0d_seq8", k), 64'(out_data[62:55]), (k == 5) ? 64'h0 : 64'(k - 1));
        check($sformatf("clr%0d_seq2", k), 64'(out_data2[62:61]), (k == 5) ? 64'h0 : 64'(k - 1));
      end
    end

    // Reset while a cookie is stalled, after rr_ptr moved off channel 0.
    @(negedge clock);
    seq_clear = 2'b00; in_valid = 2'b01; out_ready = 1'b0;
    @(negedge clock);
    in_valid = 2'b00;
    #1 check("stall_vld_before_reset", 64'(out_valid), 64'h1);
    do_reset("stall");
    @(negedge clock);
    in_valid = 2'b11; out_ready = 1'b1;
    #1 check("post_reset_grant", 64'(in_ready), 64'h1);
    @(negedge clock);
    in_valid = 2'b00;
    #1;
    check("post_reset_vld", 64'(out_valid), 64'h1);
    check("post_reset_ch", 64'(out_channel), 64'h0);
    check("post_reset_seq", 64'(out_data[62:55]), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
